ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register; directly consumes the ID/EX register outputs.
- Per instruction: selects operands (with forwarding), computes the ALU result, resolves branch/jump/jalr, and raises a redirect plus flush to fetch/decode.
- Registers the result bundle for the memory stage and holds it under a memory stall.

Parameters:
- XLEN, 32, datapath width
- RESET_PC_TGT, 0, value driven on pc_target_o while reset is asserted

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (reset=0 resets)
- rs1_i, rs2_i  in  XLEN  register operands from ID/EX
- imm_i, pc_i, pc_add4_i  in  XLEN  immediate, instruction PC, PC+4
- rd_i, rs1_addr_i, rs2_addr_i  in  5  destination and source register indices
- esc_reg_i, esc_mem_i, ula_imm_i, jump_i, branch_i, lui_i, auipc_i, jalr_i, lw_i, shamt_i  in  1  decoded controls
- alu_ctrl_i  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT
- wb_we_i  in  1  write-back stage writes register file
- wb_rd_i  in  5  write-back destination
- wb_data_i  in  XLEN  write-back value
- mem_stall_i  in  1  memory stage busy; hold EX/MEM register
- flush_o  out  1  kill IF/ID and ID/EX contents (combinational)
- pc_target_o  out  XLEN  redirect target, valid when flush_o=1
- alu_result_o, store_data_o  out  XLEN  registered result and forwarded rs2
- rd_o  out  5  registered destination
- esc_reg_o, esc_mem_o, lw_o  out  1  registered controls

Behaviour:
- Reset (reset=0, asynchronous): all registered outputs go to 0.
  - pc_target_o = RESET_PC_TGT.
  - flush_o = 0, independent of inputs.
- Forwarding (FORWARDING_EN only), evaluated per source, first match wins:
  - Match EX/MEM when esc_reg_o=1, lw_o=0, rd_o≠0 and rd_o==rs_addr; use alu_result_o.
  - Otherwise match WB when wb_we_i=1, wb_rd_i≠0 and wb_rd_i==rs_addr; use wb_data_i.
  - Otherwise use the raw operand.
  - A load in EX/MEM never forwards; the hazard unit owns the load-use stall.
- Operand A: pc_i if auipc_i; 0 if lui_i; else forwarded rs1.
- Operand B: imm_i if any of ula_imm_i, lui_i, auipc_i, shamt_i; else forwarded rs2.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - Shift amount is opB[4:0] (shamt_i selects imm_i[4:0]).
  - SRL is logical.
  - SLT is signed and yields 0 or 1.
- Result: pc_add4_i when jump_i or jalr_i; else the ALU output.
- Branch condition (branch_i=1):
  - alu_ctrl_i=111: taken when signed opA<opB (BLT).
  - alu_ctrl_i=001: taken when opA≠opB (BNE).
  - Otherwise: taken when opA==opB (BEQ).
  - Comparison uses forwarded rs1/rs2 regardless of ula_imm_i.
- Redirect:
  - taken = jump_i | jalr_i | (branch_i & cond).
  - flush_o = taken & ~mem_stall_i.
  - pc_target_o = (fwd rs1 + imm_i) & ~1 for jalr_i; else pc_i + imm_i.
  - Combinational, zero latency, same cycle as the instruction is in EX.
- EX/MEM register, rising clk:
  - mem_stall_i=0: capture result, forwarded rs2 as store_data_o, rd_i, esc_reg_i, esc_mem_i, lw_i.
  - mem_stall_i=1: hold all registered outputs; forwarding still uses the held values.
- Bubbles: an all-zero ID/EX bundle, or one with rd_i=0, produces no architectural effect; rd_o=0 is never forwarded.
- Simultaneous flush and stall: stall wins; the flush is suppressed until the stall drops, and the instruction re-evaluates then.
- Reset released mid-stream: the first edge after release captures normally.

Optional Feature:
- Macro FORWARDING_EN.
- Defined: EX/MEM and WB forwarding as above.
- Undefined: operands are rs1_i/rs2_i unmodified, the forwarding logic is absent, and the hazard unit must stall for every RAW dependency. Every other behaviour is identical.

Test Plan:
- Reset: assert reset=0 with nonzero inputs -> all registered outputs 0, flush_o=0. Release, then ADD rs1=5 rs2=7 rd=3 -> next edge alu_result_o=12, rd_o=3, esc_reg_o=1.
- Forwarding priority: back-to-back ADD x3=12, then SUB x4=x3-x1 (x1=2, stale rs1_i=0), with WB writing x3=99 in the same cycle -> alu_result_o=10, EX/MEM value wins. Without FORWARDING_EN -> 0xFFFFFFFE.
- BEQ taken: pc_i=0x40, imm_i=0x10, equal operands -> flush_o=1 and pc_target_o=0x50 in the same cycle. Unequal operands -> flush_o=0.
- JALR: rs1=0x103, imm_i=4, pc_add4_i=0x24 -> pc_target_o=0x106, and the next edge gives alu_result_o=0x24.
- Stall: mem_stall_i=1 for 3 cycles while a BNE with taken condition sits in EX -> flush_o=0 and outputs frozen. On release -> flush_o=1 and a single capture.
- Shifts/SLT: SLL by imm 31 on 1 -> 0x80000000. SLT -1 < 1 -> 1. SRL 0x80000000 by 31 -> 1.

Source files
------------

// File: rtl/ex_mem_stage.sv
// Execute stage plus EX/MEM pipeline register: operand selection, ALU, branch/jump
// resolution with same-cycle redirect. Define FORWARDING_EN for EX/MEM and WB forwarding.
module ex_mem_stage #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TGT = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_add4_i,
  input  logic [4:0]      rd_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic            esc_reg_i,
  input  logic            esc_mem_i,
  input  logic            ula_imm_i,
  input  logic            jump_i,
  input  logic            branch_i,
  input  logic            lui_i,
  input  logic            auipc_i,
  input  logic            jalr_i,
  input  logic            lw_i,
  input  logic            shamt_i,
  input  logic [2:0]      alu_ctrl_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            mem_stall_i,
  output logic            flush_o,
  output logic [XLEN-1:0] pc_target_o,
  output logic [XLEN-1:0] alu_result_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [4:0]      rd_o,
  output logic            esc_reg_o,
  output logic            esc_mem_o,
  output logic            lw_o
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] store_data_q, store_data_d;
  logic [4:0]      rd_q, rd_d;
  logic            esc_reg_q, esc_reg_d;
  logic            esc_mem_q, esc_mem_d;
  logic            lw_q, lw_d;

  logic [XLEN-1:0] fwd_a, fwd_b;
  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] alu_y;
  logic [XLEN-1:0] result;
  logic [4:0]      sh_amt;
  alu_op_e         alu_op;
  logic            br_cond;
  logic            taken;

  // ---------------------------------------------------------------- forwarding
`ifdef FORWARDING_EN
  // Loads in EX/MEM are excluded: their data is not available yet.
  logic exmem_fwd_ok;
  assign exmem_fwd_ok = esc_reg_q && !lw_q && (rd_q != 5'd0);

  always_comb begin
    fwd_a = rs1_i;
    if (exmem_fwd_ok && (rd_q == rs1_addr_i)) begin
      fwd_a = alu_result_q;
    end else if (wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1_addr_i)) begin
      fwd_a = wb_data_i;
    end
  end

  always_comb begin
    fwd_b = rs2_i;
    if (exmem_fwd_ok && (rd_q == rs2_addr_i)) begin
      fwd_b = alu_result_q;
    end else if (wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2_addr_i)) begin
      fwd_b = wb_data_i;
    end
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{rs1_addr_i, rs2_addr_i, wb_we_i, wb_rd_i, wb_data_i};

  always_comb begin
    fwd_a = rs1_i;
    fwd_b = rs2_i;
  end
`endif

  // ---------------------------------------------------------------- operands
  always_comb begin
    op_a = fwd_a;
    if (auipc_i) begin
      op_a = pc_i;
    end else if (lui_i) begin
      op_a = '0;
    end
  end

  always_comb begin
    op_b = fwd_b;
    if (ula_imm_i || lui_i || auipc_i || shamt_i) begin
      op_b = imm_i;
    end
  end

  // ---------------------------------------------------------------- ALU
  assign alu_op = alu_op_e'(alu_ctrl_i);
  assign sh_amt = op_b[4:0];

  always_comb begin
    alu_y = '0;
    unique case (alu_op)
      ALU_ADD: alu_y = op_a + op_b;
      ALU_SUB: alu_y = op_a - op_b;
      ALU_AND: alu_y = op_a & op_b;
      ALU_OR:  alu_y = op_a | op_b;
      ALU_XOR: alu_y = op_a ^ op_b;
      ALU_SLL: alu_y = op_a << sh_amt;
      ALU_SRL: alu_y = op_a >> sh_amt;
      ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_y = '0;
    endcase
  end

  assign result = (jump_i || jalr_i) ? pc_add4_i : alu_y;

  // ---------------------------------------------------------------- redirect
  // Branch compares use the forwarded registers even when op_b carries the immediate.
  always_comb begin
    br_cond = (fwd_a == fwd_b);
    if (alu_ctrl_i == 3'b111) begin
      br_cond = ($signed(fwd_a) < $signed(fwd_b));
    end else if (alu_ctrl_i == 3'b001) begin
      br_cond = (fwd_a != fwd_b);
    end
  end

  assign taken = jump_i || jalr_i || (branch_i && br_cond);

  always_comb begin
    flush_o     = 1'b0;
    pc_target_o = pc_i + imm_i;
    if (!reset) begin
      pc_target_o = RESET_PC_TGT;
    end else begin
      flush_o = taken && !mem_stall_i;
      if (jalr_i) begin
        pc_target_o = (fwd_a + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
      end
    end
  end

  // ---------------------------------------------------------------- EX/MEM register
  always_comb begin
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    rd_d         = rd_q;
    esc_reg_d    = esc_reg_q;
    esc_mem_d    = esc_mem_q;
    lw_d         = lw_q;
    if (!mem_stall_i) begin
      alu_result_d = result;
      store_data_d = fwd_b;
      rd_d         = rd_i;
      esc_reg_d    = esc_reg_i;
      esc_mem_d    = esc_mem_i;
      lw_d         = lw_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result_q <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      esc_reg_q    <= 1'b0;
      esc_mem_q    <= 1'b0;
      lw_q         <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      esc_reg_q    <= esc_reg_d;
      esc_mem_q    <= esc_mem_d;
      lw_q         <= lw_d;
    end
  end

  assign alu_result_o = alu_result_q;
  assign store_data_o = store_data_q;
  assign rd_o         = rd_q;
  assign esc_reg_o    = esc_reg_q;
  assign esc_mem_o    = esc_mem_q;
  assign lw_o         = lw_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized instruction
// stream compared against an instruction-level reference model.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [31:0] rs1, rs2, imm, pc, pc4;
    logic [4:0]  rd, a1, a2;
    logic        esc_reg, esc_mem, ula_imm, jump, branch, lui, auipc, jalr, lw, shamt;
    logic [2:0]  ctrl;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
  } stim_t;

  logic        clk, reset;
  logic [31:0] rs1_i, rs2_i, imm_i, pc_i, pc_add4_i, wb_data_i;
  logic [4:0]  rd_i, rs1_addr_i, rs2_addr_i, wb_rd_i;
  logic        esc_reg_i, esc_mem_i, ula_imm_i, jump_i, branch_i, lui_i, auipc_i, jalr_i, lw_i, shamt_i;
  logic [2:0]  alu_ctrl_i;
  logic        wb_we_i, mem_stall_i;
  logic        flush_o, esc_reg_o, esc_mem_o, lw_o;
  logic [31:0] pc_target_o, alu_result_o, store_data_o;
  logic [4:0]  rd_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the EX/MEM register contents
  logic [31:0] m_alu, m_sd;
  logic [4:0]  m_rd;
  logic        m_er, m_em, m_lw;

  ex_mem_stage #(.XLEN(32), .RESET_PC_TGT(32'h0)) dut (
    .clk(clk), .reset(reset),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i), .pc_i(pc_i), .pc_add4_i(pc_add4_i),
    .rd_i(rd_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .esc_reg_i(esc_reg_i), .esc_mem_i(esc_mem_i), .ula_imm_i(ula_imm_i), .jump_i(jump_i),
    .branch_i(branch_i), .lui_i(lui_i), .auipc_i(auipc_i), .jalr_i(jalr_i), .lw_i(lw_i),
    .shamt_i(shamt_i), .alu_ctrl_i(alu_ctrl_i),
    .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .mem_stall_i(mem_stall_i),
    .flush_o(flush_o), .pc_target_o(pc_target_o), .alu_result_o(alu_result_o),
    .store_data_o(store_data_o), .rd_o(rd_o), .esc_reg_o(esc_reg_o), .esc_mem_o(esc_mem_o),
    .lw_o(lw_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    rs1_i = s.rs1; rs2_i = s.rs2; imm_i = s.imm; pc_i = s.pc; pc_add4_i = s.pc4;
    rd_i = s.rd; rs1_addr_i = s.a1; rs2_addr_i = s.a2;
    esc_reg_i = s.esc_reg; esc_mem_i = s.esc_mem; ula_imm_i = s.ula_imm; jump_i = s.jump;
    branch_i = s.branch; lui_i = s.lui; auipc_i = s.auipc; jalr_i = s.jalr; lw_i = s.lw;
    shamt_i = s.shamt; alu_ctrl_i = s.ctrl;
    wb_we_i = s.wb_we; wb_rd_i = s.wb_rd; wb_data_i = s.wb_data; mem_stall_i = s.stall;
  endtask

  function automatic logic [31:0] model_src(input logic [4:0] addr, input logic [31:0] raw,
                                            input stim_t s);
`ifdef FORWARDING_EN
    if (m_er && !m_lw && m_rd != 0 && m_rd == addr) return m_alu;
    if (s.wb_we && s.wb_rd != 0 && s.wb_rd == addr) return s.wb_data;
`endif
    return raw;
  endfunction

  task automatic model_reset();
    m_alu = 0; m_sd = 0; m_rd = 0; m_er = 0; m_em = 0; m_lw = 0;
  endtask

  task automatic check_regs(input string pfx);
    check_eq({pfx, "_alu_result"}, alu_result_o, m_alu);
    check_eq({pfx, "_store_data"}, store_data_o, m_sd);
    check_eq({pfx, "_rd"}, {27'd0, rd_o}, {27'd0, m_rd});
    check_eq({pfx, "_esc_reg"}, {31'd0, esc_reg_o}, {31'd0, m_er});
    check_eq({pfx, "_esc_mem"}, {31'd0, esc_mem_o}, {31'd0, m_em});
    check_eq({pfx, "_lw"}, {31'd0, lw_o}, {31'd0, m_lw});
  endtask

  // One instruction slot: drive at negedge, check redirect, clock it in, check register.
  task automatic run_step(input stim_t s, output logic flush_seen, output logic [31:0] tgt_seen);
    logic [31:0] fa, fb, a, b, alu, res, tgt;
    logic        cond, tk;
    int unsigned sh;
    drive(s);
    #1;
    fa = model_src(s.a1, s.rs1, s);
    fb = model_src(s.a2, s.rs2, s);
    a  = s.auipc ? s.pc : (s.lui ? 32'd0 : fa);
    b  = (s.ula_imm || s.lui || s.auipc || s.shamt) ? s.imm : fb;
    sh = b % 32;
    case (s.ctrl)
      3'd0: alu = a + b;
      3'd1: alu = a - b;
      3'd2: alu = a & b;
      3'd3: alu = a | b;
      3'd4: alu = a ^ b;
      3'd5: alu = a << sh;
      3'd6: alu = a >> sh;
      default: alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    res = (s.jump || s.jalr) ? s.pc4 : alu;
    if (s.ctrl == 3'd7)      cond = $signed(fa) < $signed(fb);
    else if (s.ctrl == 3'd1) cond = fa != fb;
    else                     cond = fa == fb;
    tk  = s.jump || s.jalr || (s.branch && cond);
    tgt = s.jalr ? ((fa + s.imm) & 32'hFFFF_FFFE) : (s.pc + s.imm);
    flush_seen = flush_o;
    tgt_seen   = pc_target_o;
    check_eq("flush", {31'd0, flush_o}, {31'd0, tk && !s.stall});
    if (tk) check_eq("pc_target", pc_target_o, tgt);
    @(posedge clk);
    #1;
    if (!s.stall) begin
      m_alu = res; m_sd = fb; m_rd = s.rd; m_er = s.esc_reg; m_em = s.esc_mem; m_lw = s.lw;
    end
    check_regs("step");
    @(negedge clk);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    int unsigned kind;
    s = '0;
    s.rs1 = $urandom; s.rs2 = $urandom; s.imm = $urandom;
    s.pc = $urandom & 32'hFFFF_FFFC; s.pc4 = s.pc + 4;
    s.rd = 5'($urandom_range(0, 3)); s.a1 = 5'($urandom_range(0, 3)); s.a2 = 5'($urandom_range(0, 3));
    s.ctrl = 3'($urandom_range(0, 7));
    s.wb_we = 1'($urandom_range(0, 1)); s.wb_rd = 5'($urandom_range(0, 3)); s.wb_data = $urandom;
    s.stall = ($urandom_range(0, 3) == 0);
    kind = $urandom_range(0, 10);
    case (kind)
      0: s.esc_reg = 1;
      1: begin s.esc_reg = 1; s.ula_imm = 1; end
      2: begin s.esc_reg = 1; s.shamt = 1; s.ctrl = $urandom_range(0, 1) ? 3'd5 : 3'd6; end
      3: begin s.esc_reg = 1; s.lui = 1; s.ctrl = 3'd0; end
      4: begin s.esc_reg = 1; s.auipc = 1; s.ctrl = 3'd0; end
      5: begin s.esc_reg = 1; s.jump = 1; s.ctrl = 3'd0; end
      6: begin s.esc_reg = 1; s.jalr = 1; s.ula_imm = 1; s.ctrl = 3'd0; end
      7: begin
        s.branch = 1; s.rd = 0;
        s.ctrl = ($urandom_range(0, 2) == 0) ? 3'd0 : (($urandom_range(0, 1) == 0) ? 3'd1 : 3'd7);
        if ($urandom_range(0, 1) == 0) s.rs2 = s.rs1;
      end
      8: begin s.esc_reg = 1; s.lw = 1; s.ula_imm = 1; s.ctrl = 3'd0; end
      9: begin s.esc_mem = 1; s.ula_imm = 1; s.ctrl = 3'd0; s.rd = 0; end
      default: begin
        s = '0;
        s.stall = ($urandom_range(0, 3) == 0);
      end
    endcase
    return s;
  endfunction

  initial begin
    stim_t       s;
    logic        fl;
    logic [31:0] tg;
    logic [31:0] held;

    // Reset with busy, nonzero inputs including a jump
    s = '0;
    s.rs1 = 32'h1234; s.rs2 = 32'h55; s.imm = 32'h80; s.pc = 32'h100; s.pc4 = 32'h104;
    s.rd = 5'd7; s.esc_reg = 1; s.esc_mem = 1; s.lw = 1; s.jump = 1; s.ctrl = 3'd3;
    reset = 1'b0;
    drive(s);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    check_eq("reset_flush", {31'd0, flush_o}, 32'd0);
    check_eq("reset_pc_target", pc_target_o, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // ADD x3 = 5 + 7
    s = '0; s.rs1 = 5; s.rs2 = 7; s.rd = 3; s.esc_reg = 1; s.ctrl = 3'd0;
    run_step(s, fl, tg);
    check_eq("add_result", alu_result_o, 32'd12);
    check_eq("add_rd", {27'd0, rd_o}, 32'd3);
    check_eq("add_esc_reg", {31'd0, esc_reg_o}, 32'd1);

    // SUB x4 = x3 - x1 with stale rs1_i and WB also writing x3
    s = '0; s.rs1 = 0; s.rs2 = 2; s.a1 = 3; s.a2 = 1; s.rd = 4; s.esc_reg = 1; s.ctrl = 3'd1;
    s.wb_we = 1; s.wb_rd = 3; s.wb_data = 99;
    run_step(s, fl, tg);
`ifdef FORWARDING_EN
    check_eq("fwd_priority", alu_result_o, 32'd10);
`else
    check_eq("fwd_priority", alu_result_o, 32'hFFFF_FFFE);
`endif

    // BEQ taken then not taken
    s = '0; s.branch = 1; s.pc = 32'h40; s.imm = 32'h10; s.rs1 = 7; s.rs2 = 7; s.ctrl = 3'd0;
    run_step(s, fl, tg);
    check_eq("beq_taken_flush", {31'd0, fl}, 32'd1);
    check_eq("beq_taken_target", tg, 32'h50);
    s.rs2 = 8;
    run_step(s, fl, tg);
    check_eq("beq_not_taken_flush", {31'd0, fl}, 32'd0);

    // JALR
    s = '0; s.jalr = 1; s.ula_imm = 1; s.rs1 = 32'h103; s.imm = 4; s.pc4 = 32'h24;
    s.rd = 1; s.esc_reg = 1; s.ctrl = 3'd0;
    run_step(s, fl, tg);
    check_eq("jalr_target", tg, 32'h106);
    check_eq("jalr_link", alu_result_o, 32'h24);

    // BNE taken held under a 3-cycle stall
    s = '0; s.branch = 1; s.rs1 = 1; s.rs2 = 2; s.pc = 32'h200; s.imm = 32'h20; s.ctrl = 3'd1;
    s.stall = 1;
    held = alu_result_o;
    for (int i = 0; i < 3; i++) begin
      run_step(s, fl, tg);
      check_eq("stall_flush", {31'd0, fl}, 32'd0);
      check_eq("stall_frozen", alu_result_o, held);
    end
    s.stall = 0;
    run_step(s, fl, tg);
    check_eq("stall_release_flush", {31'd0, fl}, 32'd1);
    check_eq("stall_release_target", tg, 32'h220);
    check_eq("stall_release_capture", alu_result_o, 32'hFFFF_FFFF);

    // Shifts and SLT
    s = '0; s.shamt = 1; s.rs1 = 1; s.imm = 31; s.ctrl = 3'd5; s.rd = 5; s.esc_reg = 1;
    run_step(s, fl, tg);
    check_eq("sll_31", alu_result_o, 32'h8000_0000);
    s = '0; s.rs1 = 32'hFFFF_FFFF; s.rs2 = 1; s.ctrl = 3'd7; s.rd = 5; s.esc_reg = 1;
    run_step(s, fl, tg);
    check_eq("slt_signed", alu_result_o, 32'd1);
    s = '0; s.shamt = 1; s.rs1 = 32'h8000_0000; s.imm = 31; s.ctrl = 3'd6; s.rd = 5; s.esc_reg = 1;
    run_step(s, fl, tg);
    check_eq("srl_logical", alu_result_o, 32'd1);

    // Randomized stream with one asynchronous reset mid-run
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_regs("async_reset");
        check_eq("async_reset_flush", {31'd0, flush_o}, 32'd0);
        check_eq("async_reset_pc_target", pc_target_o, 32'h0);
        @(negedge clk);
        reset = 1'b1;
      end
      run_step(rand_stim(), fl, tg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
